// File: rtl/red_accum_unit.sv
// red_accum_unit
//   Sums the four signed bytes of two captured 16-bit operands over four
//   clock edges and presents the sign-extended 10-bit total as a 16-bit
//   RED result.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request an operation (sampled only while idle)
//   flush   in   1   synchronous abort, wins over start
//   rs, rt  in   16  source operands, captured on an accepted start
//   busy    out  1   high whenever the FSM is not IDLE
//   valid   out  1   high for the single DONE cycle
//   result  out  16  sign-extended sum; holds until the next completion
module red_accum_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] rs,
    input  logic [15:0] rt,
    output logic        busy,
    output logic        valid,
    output logic [15:0] result
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t      state, state_nx;
    logic [15:0] rs_q, rt_q;
    logic [9:0]  acc;
    logic [1:0]  cnt;
    logic [7:0]  byte_sel;
    logic [9:0]  sum;

    // Byte order: rs low, rs high, rt low, rt high.
    always_comb begin
        byte_sel = rs_q[7:0];
        case (cnt)
            2'd0: byte_sel = rs_q[7:0];
            2'd1: byte_sel = rs_q[15:8];
            2'd2: byte_sel = rt_q[7:0];
            2'd3: byte_sel = rt_q[15:8];
            default: byte_sel = rs_q[7:0];
        endcase
    end

    // Four bytes in -128..127 fit in -512..508, so 10 bits never overflow.
    assign sum = acc + {{2{byte_sel[7]}}, byte_sel};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACC;
            ACC:     if (cnt == 2'd3) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rs_q   <= '0;
            rt_q   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start && !flush) begin
                rs_q <= rs;
                rt_q <= rt;
                acc  <= '0;
                cnt  <= '0;
            end else if (state == ACC && !flush) begin
                acc <= sum;
                // 2-bit counter wraps 3->0 exactly on the ACC->DONE edge.
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3)
                    result <= {{6{sum[9]}}, sum};
            end
        end
    end

    assign busy  = (state != IDLE);
    // Combinational from state so a flush during DONE still shows the pulse.
    assign valid = (state == DONE);

endmodule
